shift_share_ctrl: RTL and testbench

//  Shares one SHIFT32 instance among N requesters. Adds rotate operations, which
//   are sequenced as two shifter passes.

---
 rtl/shift_share_ctrl_pkg.sv | 29 ++
 rtl/shift_share_ctrl_if.sv | 27 ++
 rtl/shift_share_ctrl_shift32.sv | 16 +
 rtl/shift_share_ctrl.sv | 151 +++++++++++++++
 tb/tb_shift_share_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_share_ctrl_pkg.sv
// Shared opcode/state encodings and helpers for the shared-shifter controller.
package shift_share_ctrl_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SH_OP_SRL = 2'b00,
        SH_OP_SLL = 2'b01,
        SH_OP_ROR = 2'b10,
        SH_OP_ROL = 2'b11
    } sh_op_e;

    typedef enum logic [1:0] {
        SH_IDLE  = 2'b00,
        SH_PASS1 = 2'b01,
        SH_PASS2 = 2'b10,
        SH_FIN   = 2'b11
    } sh_state_e;

    // Opcode bit 1 marks the rotates, bit 0 marks the left-going variants.
    function automatic logic is_rotate(input sh_op_e op);
        return op[1];
    endfunction

    function automatic logic goes_left(input sh_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/shift_share_ctrl_if.sv
// Requester-side bus of the shared shifter: packed per-requester operands and results.
interface shift_share_ctrl_if
    import shift_share_ctrl_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = 1
);
    logic [N-1:0]        req;
    logic [2*N-1:0]      op;
    logic [DATA_W*N-1:0] d;
    logic [DATA_W*N-1:0] s;
    logic [N-1:0]        gnt;
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   result;
    logic [IDW-1:0]      rid;

    modport master (
        output req, op, d, s,
        input  gnt, busy, done, result, rid
    );

    modport slave (
        input  req, op, d, s,
        output gnt, busy, done, result, rid
    );
endinterface

// File: rtl/shift_share_ctrl_shift32.sv
// SHIFT32: combinational logical shifter; amounts of 32 or more flush to zero.
module shift_share_ctrl_shift32
    import shift_share_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] amount,
    input  logic              lnr,
    output logic [DATA_W-1:0] y
);
    always_comb begin
        y = '0;
        if (amount < 32'd32) begin
            y = lnr ? (d << amount[4:0]) : (d >> amount[4:0]);
        end
    end
endmodule

// File: rtl/shift_share_ctrl.sv
// Round-robin sharing of one SHIFT32 among N requesters; rotates run as two
// shifter passes whose outputs are OR-ed together.
module shift_share_ctrl
    import shift_share_ctrl_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = 1
)(
    input  logic             clk,
    input  logic             rst,
    shift_share_ctrl_if.slave bus
);
    logic [1:0]        op_arr [N];
    logic [DATA_W-1:0] d_arr  [N];
    logic [DATA_W-1:0] s_arr  [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign op_arr[gi] = bus.op[2*gi +: 2];
            assign d_arr[gi]  = bus.d[DATA_W*gi +: DATA_W];
            assign s_arr[gi]  = bus.s[DATA_W*gi +: DATA_W];
        end
    endgenerate

    sh_state_e         state_reg, state_next;
    sh_op_e            op_reg;
    logic [DATA_W-1:0] d_reg, s_reg;
    logic [IDW-1:0]    id_reg;
    logic [IDW-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [DATA_W-1:0] partial_reg, partial_next;
    logic [N-1:0]      gnt_reg, gnt_next;
    logic              done_reg;
    logic [DATA_W-1:0] result_reg;
    logic [IDW-1:0]    rid_reg;

    logic              win_found;
    logic [IDW-1:0]    win_idx;
    logic [IDW-1:0]    cand_idx;
    logic              capture, finish;
    logic [DATA_W-1:0] sh_amt, sh_out;
    logic              sh_lnr;
    logic [4:0]        rot_amt;

    assign rot_amt = s_reg[4:0];

    // Search upward from rr_ptr, wrapping modulo N; first asserted REQ wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand_idx = IDW'((int'(rr_ptr_reg) + k) % N);
            if (!win_found && bus.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        rr_ptr_next = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
    end

    shift_share_ctrl_shift32 u_shift32 (
        .d      (d_reg),
        .amount (sh_amt),
        .lnr    (sh_lnr),
        .y      (sh_out)
    );

    always_comb begin
        state_next   = state_reg;
        capture      = 1'b0;
        finish       = 1'b0;
        gnt_next     = '0;
        sh_amt       = s_reg;
        sh_lnr       = 1'b0;
        partial_next = partial_reg;
        case (state_reg)
            SH_IDLE: begin
                if (win_found) begin
                    capture           = 1'b1;
                    gnt_next[win_idx] = 1'b1;
                    state_next        = SH_PASS1;
                end
            end
            SH_PASS1: begin
                sh_lnr       = goes_left(op_reg);
                sh_amt       = is_rotate(op_reg) ? {27'b0, rot_amt} : s_reg;
                partial_next = sh_out;
                if (!is_rotate(op_reg) || rot_amt == 5'd0) begin
                    state_next = SH_FIN;
                    finish     = 1'b1;
                end else begin
                    state_next = SH_PASS2;
                end
            end
            SH_PASS2: begin
                // Bring back the bits that fell off the far end in the first pass.
                sh_lnr       = ~goes_left(op_reg);
                sh_amt       = DATA_W'(6'd32 - {1'b0, rot_amt});
                partial_next = partial_reg | sh_out;
                state_next   = SH_FIN;
                finish       = 1'b1;
            end
            SH_FIN: begin
                state_next = SH_IDLE;
            end
            default: begin
                state_next = SH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= SH_IDLE;
            op_reg      <= SH_OP_SRL;
            d_reg       <= '0;
            s_reg       <= '0;
            id_reg      <= '0;
            rr_ptr_reg  <= '0;
            partial_reg <= '0;
            gnt_reg     <= '0;
            done_reg    <= 1'b0;
            result_reg  <= '0;
            rid_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            partial_reg <= partial_next;
            gnt_reg     <= gnt_next;
            done_reg    <= finish;
            if (capture) begin
                op_reg     <= sh_op_e'(op_arr[win_idx]);
                d_reg      <= d_arr[win_idx];
                s_reg      <= s_arr[win_idx];
                id_reg     <= win_idx;
                rr_ptr_reg <= rr_ptr_next;
            end
            // Result lands on the edge entering FIN, so DONE and RESULT align.
            if (finish) begin
                result_reg <= partial_next;
                rid_reg    <= id_reg;
            end
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.busy   = (state_reg != SH_IDLE);
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
    assign bus.rid    = rid_reg;

endmodule

// File: tb/tb_shift_share_ctrl.sv
// Directed bench for shift_share_ctrl with two requesters and hand-computed results.
module tb_shift_share_ctrl;
    localparam int N   = 2;
    localparam int IDW = 1;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    shift_share_ctrl_if #(.N(N), .IDW(IDW)) bus ();

    shift_share_ctrl #(.N(N), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Issue one request, then scramble its operands right after the grant.
    task automatic run_op(input int id, input logic [1:0] op, input logic [31:0] dv,
                          input logic [31:0] sv, output logic [N-1:0] g,
                          output logic [N-1:0] g_after, output int lat,
                          output logic [31:0] res, output logic [IDW-1:0] r_id,
                          output logic busy_g, output logic busy_d,
                          output logic busy_after, output logic done_after,
                          output bit to);
        to = 1'b0; g = '0; g_after = '0; lat = 0; res = '0; r_id = '0;
        busy_g = 1'b0; busy_d = 1'b0; busy_after = 1'b0; done_after = 1'b0;
        @(negedge clk);
        bus.op[2*id +: 2]  = op;
        bus.d[32*id +: 32] = dv;
        bus.s[32*id +: 32] = sv;
        bus.req[id]        = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) break;
        end
        g = bus.gnt;
        busy_g = bus.busy;
        if (g == '0) to = 1'b1;
        bus.req[id]        = 1'b0;
        bus.op[2*id +: 2]  = ~op;
        bus.d[32*id +: 32] = ~dv;
        bus.s[32*id +: 32] = sv ^ 32'h5A5A_0003;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) g_after = bus.gnt;
            if (bus.done) break;
        end
        if (!bus.done) to = 1'b1;
        res = bus.result;
        r_id = bus.rid;
        busy_d = bus.busy;
        @(negedge clk);
        busy_after = bus.busy;
        done_after = bus.done;
    endtask

    task automatic test_reset();
        logic [N-1:0] g;
        rst = 1'b1;
        bus.req = '0; bus.op = '0; bus.d = '0; bus.s = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({bus.gnt, bus.busy, bus.done, bus.result, bus.rid} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b result=%h rid=%h required all 0",
                     bus.gnt, bus.busy, bus.done, bus.result, bus.rid);
        end
        rst = 1'b0;
        // Start a rotate from req0 (moves rr_ptr to 1), then reset in PASS1.
        bus.op[1:0] = 2'b10; bus.d[31:0] = 32'h8000_0001; bus.s[31:0] = 32'd4;
        bus.req[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) break;
        end
        compared++;
        if (bus.gnt !== 2'b01) begin
            mismatched++;
            $display("FAIL reset_pre_grant: got %b required 01", bus.gnt);
        end
        bus.req = '0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            compared++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_midop: got done=%b busy=%b required 0 0", bus.done, bus.busy);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            compared++;
            if ({bus.gnt, bus.busy, bus.done, bus.result, bus.rid} !== '0) begin
                mismatched++;
                $display("FAIL reset_after: got gnt=%b busy=%b done=%b result=%h rid=%h required all 0",
                         bus.gnt, bus.busy, bus.done, bus.result, bus.rid);
            end
        end
        bus.op = 4'b0000;
        bus.d  = {32'hF000_0000, 32'hF000_0000};
        bus.s  = {32'd28, 32'd28};
        bus.req = 2'b11;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) break;
        end
        g = bus.gnt;
        bus.req = '0;
        compared++;
        if (g !== 2'b01) begin
            mismatched++;
            $display("FAIL reset_rr_ptr: got gnt=%b required 01", g);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        compared++;
        if (bus.done !== 1'b1 || bus.result !== 32'h0000_000F || bus.rid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_first_op: got done=%b result=%h rid=%h required 1 0000000f 0",
                     bus.done, bus.result, bus.rid);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sll();
        logic [N-1:0] g, ga; int lat; logic [31:0] res; logic [IDW-1:0] rid;
        logic bg, bd, ba, da; bit to;
        run_op(0, 2'b01, 32'h0000_0001, 32'd4, g, ga, lat, res, rid, bg, bd, ba, da, to);
        compared++;
        if (to || g !== 2'b01 || ga !== 2'b00) begin
            mismatched++;
            $display("FAIL sll_grant: got gnt=%b next=%b timeout=%0d required 01 00 0", g, ga, to);
        end
        compared++;
        if (lat != 1 || da !== 1'b0) begin
            mismatched++;
            $display("FAIL sll_latency: got %0d cycles after grant (done_after=%b) required 1 (0)", lat, da);
        end
        compared++;
        if (res !== 32'h0000_0010 || rid !== 1'b0) begin
            mismatched++;
            $display("FAIL sll_result: got %h rid=%h required 00000010 rid=0", res, rid);
        end
    endtask

    task automatic test_ror();
        logic [N-1:0] g, ga; int lat; logic [31:0] res; logic [IDW-1:0] rid;
        logic bg, bd, ba, da; bit to;
        run_op(1, 2'b10, 32'h8000_0001, 32'd4, g, ga, lat, res, rid, bg, bd, ba, da, to);
        compared++;
        if (to || g !== 2'b10 || ga !== 2'b00) begin
            mismatched++;
            $display("FAIL ror_grant: got gnt=%b next=%b timeout=%0d required 10 00 0", g, ga, to);
        end
        compared++;
        if (lat != 2) begin
            mismatched++;
            $display("FAIL ror_latency: got %0d cycles after grant required 2", lat);
        end
        compared++;
        if (res !== 32'h1800_0000 || rid !== 1'b1) begin
            mismatched++;
            $display("FAIL ror_result: got %h rid=%h required 18000000 rid=1", res, rid);
        end
    endtask

    task automatic test_round_robin();
        int gcount = 0;
        int dcount = 0;
        logic [N-1:0] exp_g;
        bus.op  = 4'b0000;
        bus.d   = {32'hF000_0000, 32'hF000_0000};
        bus.s   = {32'd28, 32'd28};
        @(negedge clk);
        bus.req = 2'b11;
        for (int c = 0; c < 60 && dcount < 6; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                exp_g = (gcount % 2 == 0) ? 2'b01 : 2'b10;
                compared++;
                if (bus.gnt !== exp_g) begin
                    mismatched++;
                    $display("FAIL rr_grant%0d: got %b required %b", gcount, bus.gnt, exp_g);
                end
                gcount++;
                if (gcount == 6) bus.req = '0;
            end
            if (bus.done) begin
                compared++;
                if (bus.result !== 32'h0000_000F || bus.rid !== IDW'(dcount % 2)) begin
                    mismatched++;
                    $display("FAIL rr_result%0d: got %h rid=%h required 0000000f rid=%0d",
                             dcount, bus.result, bus.rid, dcount % 2);
                end
                dcount++;
            end
        end
        bus.req = '0;
        compared++;
        if (gcount != 6 || dcount != 6) begin
            mismatched++;
            $display("FAIL rr_count: got %0d grants %0d dones required 6 6", gcount, dcount);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_boundaries();
        logic [N-1:0] g, ga; int lat; logic [31:0] res; logic [IDW-1:0] rid;
        logic bg, bd, ba, da; bit to;
        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0020, g, ga, lat, res, rid, bg, bd, ba, da, to);
        compared++;
        if (to || res !== 32'h0 || lat != 1) begin
            mismatched++;
            $display("FAIL srl_32: got %h lat=%0d timeout=%0d required 00000000 lat=1", res, lat, to);
        end
        run_op(1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, g, ga, lat, res, rid, bg, bd, ba, da, to);
        compared++;
        if (to || res !== 32'h0 || rid !== 1'b1) begin
            mismatched++;
            $display("FAIL sll_max: got %h rid=%h timeout=%0d required 00000000 rid=1", res, rid, to);
        end
        run_op(0, 2'b11, 32'h1234_5678, 32'h0000_0020, g, ga, lat, res, rid, bg, bd, ba, da, to);
        compared++;
        if (to || res !== 32'h1234_5678 || lat != 1) begin
            mismatched++;
            $display("FAIL rol_r0: got %h lat=%0d timeout=%0d required 12345678 lat=1", res, lat, to);
        end
        run_op(1, 2'b10, 32'h8000_0001, 32'hFFFF_FFE4, g, ga, lat, res, rid, bg, bd, ba, da, to);
        compared++;
        if (to || res !== 32'h1800_0000 || lat != 2) begin
            mismatched++;
            $display("FAIL ror_hi_ignored: got %h lat=%0d timeout=%0d required 18000000 lat=2", res, lat, to);
        end
    endtask

    task automatic test_operand_hold();
        logic [N-1:0] g, ga; int lat; logic [31:0] res; logic [IDW-1:0] rid;
        logic bg, bd, ba, da; bit to;
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_idle_busy: got %b required 0", bus.busy);
        end
        run_op(0, 2'b11, 32'h0000_000F, 32'd8, g, ga, lat, res, rid, bg, bd, ba, da, to);
        compared++;
        if (to || res !== 32'h0000_0F00 || lat != 2) begin
            mismatched++;
            $display("FAIL hold_result: got %h lat=%0d timeout=%0d required 00000f00 lat=2", res, lat, to);
        end
        compared++;
        if (bg !== 1'b1 || bd !== 1'b1 || ba !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_busy: got grant=%b fin=%b after=%b required 1 1 0", bg, bd, ba);
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_ror();
        test_round_robin();
        test_boundaries();
        test_operand_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
